sig_dump_monitor: RTL and testbench

SIG_DUMP_MONITOR -- requirements
Module: sig_dump_monitor

---
 rtl/sig_dump_pkg.sv | 27 ++
 rtl/sig_dump_fifo.sv | 55 +++++
 rtl/sig_dump_monitor.sv | 150 +++++++++++++++
 tb/tb_sig_dump_monitor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_dump_pkg.sv
// Shared types for the signature/dump monitor:
// FSM states, done-cause bit positions and the FIFO record.
package sig_dump_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_GRACE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CAUSE_STOP   = 0;
  localparam int CAUSE_SIMLEN = 1;

  localparam int REC_CH_W  = 8;
  localparam int REC_VAL_W = 128;

  // Sized for the widest channel/dump configuration; narrower
  // builds zero-fill the upper bits.
  typedef struct packed {
    logic [REC_CH_W-1:0]  ch;
    logic [15:0]          idx;
    logic [REC_VAL_W-1:0] value;
    logic [REC_VAL_W-1:0] value_t0;
  } record_t;

endpackage

// File: rtl/sig_dump_fifo.sv
// Synchronous first-word-fall-through record FIFO.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module sig_dump_fifo
  import sig_dump_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  record_t                din_i,
  input  logic                   pop_i,
  output record_t                dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  record_t mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign count_o = count;
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign dout_o  = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sig_dump_monitor.sv
// Snoops memory writes, captures per-channel dump values into a FIFO
// and sequences RUN -> GRACE -> DRAIN -> DONE on stop/simlen.
module sig_dump_monitor
  import sig_dump_pkg::*;
#(
  parameter int ADDR_WIDTH   = 21,
  parameter int DATA_WIDTH   = 128,
  parameter int DUMP_WIDTH   = 64,
  parameter int NUM_CH       = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_ADDR    = 0,
  parameter int CH_BASE_ADDR = 1,
  parameter int STOP_GRACE   = 50,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_t0_i,
  input  logic [NUM_CH-1:0]     ch_en_i,
  input  logic [31:0]           simlen_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CH_W-1:0]       out_ch_o,
  output logic [15:0]           out_idx_o,
  output logic [DUMP_WIDTH-1:0] out_value_o,
  output logic [DUMP_WIDTH-1:0] out_value_t0_o,
  output logic [1:0]            state_o,
  output logic                  done_o,
  output logic [1:0]            done_cause_o,
  output logic [NUM_CH-1:0]     overflow_o,
  output logic [31:0]           cycle_cnt_o
);

  state_t      state;
  logic [15:0] idx [NUM_CH];
  logic [31:0] grace_cnt;
  logic [31:0] cycle_cnt;
  logic [1:0]  cause;
  logic [NUM_CH-1:0] overflow;

  logic hit, ch_hit, push, pop, drop;
  logic stop_hit, lim_hit, run_like;
  logic [CH_W-1:0] sel;
  logic fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  record_t rec_in, rec_out;

  assign hit      = mem_req_i && mem_we_i;
  assign run_like = (state == S_RUN) || (state == S_GRACE);
  assign stop_hit = hit && (state == S_RUN) &&
                    (mem_addr_i == ADDR_WIDTH'(STOP_ADDR));
  assign lim_hit  = run_like && (simlen_i != '0) &&
                    (cycle_cnt == simlen_i - 32'd1);

  always_comb begin
    ch_hit = 1'b0;
    sel    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_en_i[c] &&
          mem_addr_i == ADDR_WIDTH'(CH_BASE_ADDR + c)) begin
        ch_hit = 1'b1;
        sel    = CH_W'(c);
      end
    end
  end

  assign push = hit && ch_hit && (state == S_RUN);
  assign pop  = out_valid_o && out_ready_i;
  assign drop = push && fifo_full && !pop;

  always_comb begin
    rec_in          = '0;
    rec_in.ch       = REC_CH_W'(sel);
    rec_in.idx      = idx[sel];
    rec_in.value    = REC_VAL_W'(mem_wdata_i[DUMP_WIDTH-1:0]);
    rec_in.value_t0 = REC_VAL_W'(mem_wdata_t0_i[DUMP_WIDTH-1:0]);
  end

  sig_dump_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .din_i  (rec_in),
    .pop_i  (pop),
    .dout_o (rec_out),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_RUN;
      cycle_cnt <= '0;
      cause     <= '0;
      overflow  <= '0;
      grace_cnt <= 32'(STOP_GRACE);
      for (int c = 0; c < NUM_CH; c++) idx[c] <= '0;
    end else begin
      if (push) begin
        idx[sel] <= idx[sel] + 16'd1;
        if (drop) overflow[sel] <= 1'b1;
      end
      if (run_like) cycle_cnt <= cycle_cnt + 32'd1;
      unique case (state)
        S_RUN: begin
          if (stop_hit) cause[CAUSE_STOP] <= 1'b1;
          if (lim_hit) cause[CAUSE_SIMLEN] <= 1'b1;
          if (lim_hit || (stop_hit && STOP_GRACE == 0)) begin
            state <= S_DRAIN;
          end else if (stop_hit) begin
            state     <= S_GRACE;
            grace_cnt <= 32'(STOP_GRACE);
          end
        end
        S_GRACE: begin
          grace_cnt <= grace_cnt - 32'd1;
          if (lim_hit) begin
            cause[CAUSE_SIMLEN] <= 1'b1;
            state <= S_DRAIN;
          end else if (grace_cnt <= 32'd1) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: if (fifo_empty) state <= S_DONE;
        S_DONE:  state <= S_DONE;
        default: state <= S_RUN;
      endcase
    end
  end

  // Payload reads as zero whenever nothing is queued.
  assign out_valid_o    = !fifo_empty;
  assign out_ch_o       = fifo_empty ? '0 : rec_out.ch[CH_W-1:0];
  assign out_idx_o      = fifo_empty ? '0 : rec_out.idx;
  assign out_value_o    = fifo_empty ? '0 : rec_out.value[DUMP_WIDTH-1:0];
  assign out_value_t0_o = fifo_empty ? '0 : rec_out.value_t0[DUMP_WIDTH-1:0];
  assign state_o        = state;
  assign done_o         = (state == S_DONE);
  assign done_cause_o   = cause;
  assign overflow_o     = overflow;
  assign cycle_cnt_o    = cycle_cnt;

endmodule

// File: tb/tb_sig_dump_monitor.sv
// Scoreboard bench for sig_dump_monitor: expected records are queued
// at write time and compared as the DUT hands them out.
module tb_sig_dump_monitor;

  localparam int AW = 21;
  localparam int DW = 128;
  localparam int VW = 64;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          mem_req_i, mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i, mem_wdata_t0_i;
  logic [1:0]    ch_en_i;
  logic [31:0]   simlen_i;
  logic          out_valid_o, out_ready_i;
  logic [0:0]    out_ch_o;
  logic [15:0]   out_idx_o;
  logic [VW-1:0] out_value_o, out_value_t0_o;
  logic [1:0]    state_o;
  logic          done_o;
  logic [1:0]    done_cause_o;
  logic [1:0]    overflow_o;
  logic [31:0]   cycle_cnt_o;

  always #5 clk = ~clk;

  sig_dump_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DUMP_WIDTH(VW),
    .NUM_CH(2), .FIFO_DEPTH(8), .STOP_ADDR(0),
    .CH_BASE_ADDR(1), .STOP_GRACE(50)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_wdata_t0_i(mem_wdata_t0_i), .ch_en_i(ch_en_i),
    .simlen_i(simlen_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_ch_o(out_ch_o),
    .out_idx_o(out_idx_o), .out_value_o(out_value_o),
    .out_value_t0_o(out_value_t0_o), .state_o(state_o),
    .done_o(done_o), .done_cause_o(done_cause_o),
    .overflow_o(overflow_o), .cycle_cnt_o(cycle_cnt_o)
  );

  typedef struct {
    logic        ch;
    logic [15:0] idx;
    logic [63:0] v;
    logic [63:0] t;
  } exp_t;

  exp_t        q[$];
  logic [15:0] idx_m [2];
  int          n_run = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare on the falling edge, then advance past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        chk("unexp_rec", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk("rec_ch", 64'(out_ch_o), 64'(e.ch));
        chk("rec_idx", 64'(out_idx_o), 64'(e.idx));
        chk("rec_val", out_value_o, e.v);
        chk("rec_t0", out_value_t0_o, e.t);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    out_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    q.delete();
    idx_m[0] = '0;
    idx_m[1] = '0;
  endtask

  task automatic wr(input int addr, input logic [63:0] d,
                    input logic [63:0] t, input bit enq, input bit adv);
    int c;
    mem_req_i = 1'b1;
    mem_we_i = 1'b1;
    mem_addr_i = AW'(addr);
    mem_wdata_i = {~d, d};
    mem_wdata_t0_i = {d, t};
    if (adv) begin
      c = addr - 1;
      if (enq) q.push_back('{ch: c[0], idx: idx_m[c], v: d, t: t});
      idx_m[c] = idx_m[c] + 16'd1;
    end
    tick();
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    logic [31:0] c0;
    mem_addr_i = '0;
    mem_wdata_i = '0;
    mem_wdata_t0_i = '0;
    ch_en_i = 2'b11;
    simlen_i = '0;
    do_reset();

    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_cnt", 64'(cycle_cnt_o), 64'd0);
    chk("rst_cause", 64'(done_cause_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_val", out_value_o, 64'd0);

    out_ready_i = 1'b1;
    wr(1, 64'hA, 64'h1A, 1, 1);
    wr(1, 64'hB, 64'h1B, 1, 1);
    wr(2, 64'hC, 64'h1C, 1, 1);
    ch_en_i = 2'b01;
    wr(2, 64'hD, 64'h1D, 0, 0);
    wr(5, 64'hE, 64'h1E, 0, 0);
    ch_en_i = 2'b11;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = AW'(1);
    tick();
    mem_req_i = 1'b0;
    repeat (3) tick();
    chk("basic_sb", 64'(q.size()), 64'd0);

    out_ready_i = 1'b0;
    wr(2, 64'h0123_4567_89AB_CDEF, 64'hF0F0, 1, 1);
    chk("lat_valid", 64'(out_valid_o), 64'd1);
    chk("lat_idx", 64'(out_idx_o), 64'd1);
    out_ready_i = 1'b1;
    repeat (2) tick();
    chk("lat_sb", 64'(q.size()), 64'd0);

    do_reset();
    for (int i = 0; i < 10; i++)
      wr(1, 64'(100 + i), 64'(200 + i), i < 8, 1);
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    chk("ovf_hold0", out_value_o, 64'd100);
    tick();
    chk("ovf_hold1", out_value_o, 64'd100);
    out_ready_i = 1'b1;
    repeat (10) tick();
    chk("ovf_sb", 64'(q.size()), 64'd0);
    wr(1, 64'h55, 64'h66, 1, 1);
    repeat (2) tick();
    chk("ovf_next", 64'(q.size()), 64'd0);

    do_reset();
    for (int i = 0; i < 8; i++)
      wr(1, 64'(300 + i), 64'(i), 1, 1);
    chk("full_valid", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b1;
    wr(1, 64'h99, 64'h98, 1, 1);
    chk("full_no_ovf", 64'(overflow_o), 64'd0);
    repeat (10) tick();
    chk("full_sb", 64'(q.size()), 64'd0);

    do_reset();
    out_ready_i = 1'b1;
    repeat (5) tick();
    wr(0, 64'h0, 64'h0, 0, 0);
    chk("stop_grace", 64'(state_o), 64'd1);
    chk("stop_cause", 64'(done_cause_o), 64'd1);
    g = 1;
    for (int k = 2; k <= 50; k++) begin
      mem_req_i = (k % 7 == 0);
      mem_we_i = 1'b1;
      mem_addr_i = AW'(1);
      tick();
      if (state_o == 2'd1) g++;
    end
    mem_req_i = 1'b0;
    chk("grace_len", 64'(g), 64'd50);
    chk("grace_norec", 64'(out_valid_o), 64'd0);
    tick();
    chk("stop_drain", 64'(state_o), 64'd2);
    chk("stop_cnt", 64'(cycle_cnt_o), 64'd56);
    c0 = cycle_cnt_o;
    tick();
    chk("stop_done", 64'(done_o), 64'd1);
    repeat (3) tick();
    chk("stop_final", 64'(state_o), 64'd3);
    chk("stop_frz", 64'(cycle_cnt_o), 64'(c0));

    do_reset();
    simlen_i = 32'd20;
    n = 0;
    while (state_o != 2'd2 && n < 40) begin
      tick();
      n++;
    end
    chk("lim_drain", 64'(state_o), 64'd2);
    chk("lim_cnt", 64'(cycle_cnt_o), 64'd20);
    chk("lim_cause", 64'(done_cause_o), 64'd2);
    repeat (2) tick();
    chk("lim_frz", 64'(cycle_cnt_o), 64'd20);
    chk("lim_done", 64'(state_o), 64'd3);

    do_reset();
    simlen_i = 32'd5;
    n = 0;
    while (cycle_cnt_o != 32'd4 && n < 20) begin
      tick();
      n++;
    end
    wr(0, 64'h0, 64'h0, 0, 0);
    chk("both_state", 64'(state_o), 64'd2);
    chk("both_cause", 64'(done_cause_o), 64'd3);
    simlen_i = '0;

    do_reset();
    wr(1, 64'h11, 64'h1, 1, 1);
    wr(2, 64'h22, 64'h2, 1, 1);
    wr(1, 64'h33, 64'h3, 1, 1);
    wr(0, 64'h0, 64'h0, 0, 0);
    repeat (50) tick();
    chk("rd_drain", 64'(state_o), 64'd2);
    chk("rd_valid", 64'(out_valid_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rd_valid0", 64'(out_valid_o), 64'd0);
    chk("rd_run", 64'(state_o), 64'd0);
    chk("rd_cnt", 64'(cycle_cnt_o), 64'd0);
    q.delete();
    idx_m[0] = '0;
    idx_m[1] = '0;
    out_ready_i = 1'b1;
    wr(1, 64'h44, 64'h4, 1, 1);
    wr(2, 64'h55, 64'h5, 1, 1);
    repeat (3) tick();
    chk("rd_sb", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
